morse_key_timer: RTL and testbench

//   Upstream stage of morse_top. Converts one raw straight-key (push button) input into

---
 rtl/morse_key_timer.sv | 144 ++++++++++++++
 tb/tb_morse_key_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_timer.sv
// Straight-key front end: sync, debounce, and mark/gap timing into dot/dash/space pulses.
// Optional sidetone divider is built only when MORSE_SIDETONE_EN is defined.
module morse_key_timer #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int UNIT_CYC     = 1000,
  parameter int DASH_UNITS   = 2,
  parameter int CHAR_UNITS   = 3,
  parameter int WORD_UNITS   = 7,
  parameter int TONE_DIV     = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic dot_out,
  output logic dash_out,
  output logic char_space_out,
  output logic word_space_out,
  output logic key_db,
  output logic busy,
  output logic sidetone_out
);
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PSW = $clog2(UNIT_CYC);

  typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;
  state_t state;

  logic           sync1, sync2, db_prev;
  logic [DBW-1:0] db_cnt;
  logic [PSW-1:0] pre;
  logic [3:0]     units, units_nxt;
  logic           rise, fall, db_edge, tick;

  assign rise      = key_db & ~db_prev;
  assign fall      = ~key_db & db_prev;
  assign db_edge   = rise | fall;
  assign tick      = (pre == PSW'(UNIT_CYC - 1)) && !db_edge;
  assign units_nxt = (units == 4'hf) ? units : units + 4'd1;
  assign busy      = (state != IDLE);

  // key_db flips only after DEBOUNCE_CYC consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      key_db  <= 1'b0;
      db_prev <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync1   <= key_in;
      sync2   <= sync1;
      db_prev <= key_db;
      if (sync2 != key_db) begin
        if (db_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
          key_db <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Unit timebase restarts on every debounced edge so marks and gaps are timed from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre   <= '0;
      units <= '0;
    end else if (db_edge) begin
      pre   <= '0;
      units <= '0;
    end else if (tick) begin
      pre   <= '0;
      units <= units_nxt;
    end else begin
      pre   <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dot_out        <= 1'b0;
      dash_out       <= 1'b0;
      char_space_out <= 1'b0;
      word_space_out <= 1'b0;
    end else begin
      dot_out        <= 1'b0;
      dash_out       <= 1'b0;
      char_space_out <= 1'b0;
      word_space_out <= 1'b0;
      case (state)
        IDLE: if (rise) state <= MARK;
        MARK: if (fall) begin
          if (units < 4'(DASH_UNITS)) dot_out  <= 1'b1;
          else                        dash_out <= 1'b1;
          state <= GAP;
        end
        GAP: begin
          if (rise) begin
            state <= MARK;
          end else if (tick) begin
            if (units_nxt == 4'(CHAR_UNITS)) begin
              char_space_out <= 1'b1;
            end else if (units_nxt == 4'(WORD_UNITS)) begin
              word_space_out <= 1'b1;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MORSE_SIDETONE_EN
  localparam int TW = $clog2(TONE_DIV + 1);
  logic [TW-1:0] tone_ph;
  logic          tone_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_ph <= '0;
      tone_q  <= 1'b0;
    end else if (!key_db) begin
      tone_ph <= '0;
      tone_q  <= 1'b0;
    end else if (tone_ph == TW'(TONE_DIV - 1)) begin
      tone_ph <= '0;
      tone_q  <= ~tone_q;
    end else begin
      tone_ph <= tone_ph + 1'b1;
    end
  end

  // gate with key_db so the tone stops on the release cycle itself
  assign sidetone_out = tone_q & key_db;
`else
  assign sidetone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_key_timer.sv
// Random key sequences against a duration-based reference model with a pulse scoreboard.
module tb_morse_key_timer;
  localparam int UC = 10, DB = 4, DASH = 2, CH = 3, WD = 7, TD = 5;
  // key_in change -> debounced edge detected: 2 sync + DB debounce
  localparam int LAT = 2 + DB;

  logic clk = 1'b0;
  logic rst, key_in;
  logic dot_out, dash_out, char_space_out, word_space_out, key_db, busy, sidetone_out;

  morse_key_timer #(
    .DEBOUNCE_CYC(DB), .UNIT_CYC(UC), .DASH_UNITS(DASH),
    .CHAR_UNITS(CH), .WORD_UNITS(WD), .TONE_DIV(TD)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .dot_out(dot_out), .dash_out(dash_out),
    .char_space_out(char_space_out), .word_space_out(word_space_out),
    .key_db(key_db), .busy(busy), .sidetone_out(sidetone_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int kind; int at;} ev_t;
  ev_t exp_q[$];
  string names[4] = '{"dot", "dash", "char", "word"};

  int total = 0, bad = 0;
  int last_rise = 0;
  bit have_mark = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic hold(input bit lvl, input int n);
    key_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark(input int n);
    last_rise = cyc + 1;
    have_mark = 1;
    hold(1'b1, n);
  endtask

  // Expected pulses for the mark just ended and a gap of g cycles. Full units
  // counted are those completed strictly before the next edge (edge beats tick).
  task automatic gap_events(input int g);
    int len, u, f;
    if (have_mark) begin
      len = cyc + 1 - last_rise;
      u   = (len - 1) / UC;
      if (u > 15) u = 15;
      f   = cyc + 1 + LAT;
      push_ev((u >= DASH) ? 1 : 0, f);
      if (g > CH * UC) push_ev(2, f + CH * UC);
      if (g > WD * UC) push_ev(3, f + WD * UC);
    end
    have_mark = 0;
  endtask

  task automatic gap(input int g);
    gap_events(g);
    hold(1'b0, g);
  endtask

  task automatic glitch(input int len);
    key_in = 1'b1;
    repeat (len) @(negedge clk);
    key_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("glitch%0d_key_db", len), int'(key_db), 0);
    end
  endtask

  // Scoreboard monitor
  int   mk, mkind;
  ev_t  me;
`ifdef MORSE_SIDETONE_EN
  int   ph_start = 0;
  logic prev_tone = 1'b0;
`endif
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mk = int'(dot_out) + int'(dash_out) + int'(char_space_out) + int'(word_space_out);
      if (mk > 1) begin
        check("one_pulse_at_a_time", mk, 1);
      end else if (mk == 1) begin
        mkind = dot_out ? 0 : dash_out ? 1 : char_space_out ? 2 : 3;
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_%s", names[mkind]), cyc, -1);
        end else begin
          me = exp_q.pop_front();
          check($sformatf("kind_%s", names[me.kind]), mkind, me.kind);
          check($sformatf("time_%s", names[me.kind]), cyc, me.at);
        end
      end
`ifdef MORSE_SIDETONE_EN
      if (!key_db) begin
        if (sidetone_out) check("tone_while_up", 1, 0);
        ph_start = cyc + 1;
      end else if (sidetone_out != prev_tone) begin
        check("tone_half_period", cyc - ph_start, TD);
        ph_start = cyc;
      end
      prev_tone = sidetone_out;
`else
      if (sidetone_out) check("tone_disabled", 1, 0);
`endif
    end
  end

  int l, g, c0;

  initial begin
    rst = 1'b1;
    key_in = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_dot", int'(dot_out), 0);
    check("rst_dash", int'(dash_out), 0);
    check("rst_char", int'(char_space_out), 0);
    check("rst_word", int'(word_space_out), 0);
    check("rst_key_db", int'(key_db), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tone", int'(sidetone_out), 0);

    // release with key held: first mark of 15 cycles counted from release
    rst = 1'b0;
    c0 = cyc;
    last_rise = cyc + 1;
    have_mark = 1;
    repeat (5) @(negedge clk);
    check("key_db_before_6", int'(key_db), 0);
    @(negedge clk);
    check("key_db_at_6", int'(key_db), 1);
    check("key_db_delay", cyc - c0, 6);
    hold(1'b1, 9);
    gap(100);
    check("busy_after_word", int'(busy), 0);

    mark(40);
    check("busy_in_mark", int'(busy), 1);
    gap(100);

    // two dots with an intra-character gap, then glitches while idle
    mark(15); gap(15);
    mark(15);
    gap_events(100);
    hold(1'b0, 80);
    glitch(2);
    hold(1'b0, 6);
    glitch(DB - 1);
    hold(1'b0, 20);

    // boundaries: 2 units exactly is still a dot, gap ending on a tick gives no space
    mark(20);  gap(30);
    mark(21);  gap(31);
    mark(20);  gap(70);
    mark(21);  gap(71);
    mark(200); gap(100);

    // reset mid-mark discards the symbol
    mark(25);
    rst = 1'b1;
    key_in = 1'b0;
    have_mark = 0;
    repeat (3) @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_key_db", int'(key_db), 0);
    rst = 1'b0;
    hold(1'b0, 30);

    for (int i = 0; i < 40; i++) begin
      l = ($urandom_range(0, 7) == 0) ? 20 + int'($urandom_range(0, 1)) : int'($urandom_range(5, 60));
      case ($urandom_range(0, 5))
        0: g = int'($urandom_range(5, 29));
        1: g = CH * UC;
        2: g = int'($urandom_range(31, 69));
        3: g = WD * UC;
        4: g = int'($urandom_range(71, 110));
        default: g = 15;
      endcase
      if (i == 39) g = 100;
      mark(l);
      gap(g);
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("busy_final", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
